muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width; every width and latency below is expressed for WIDTH=32.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled on rising clk edges.
REQ-005 ALUControl  input  4  operation select: 0100 MUL, 0110 UMULL, 1000 SMULL, 0111 DIV (unsigned); all other codes are unsupported.
REQ-006 SrcA  input  32  multiplicand or dividend.
REQ-007 SrcB  input  32  multiplier or divisor.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 ResultLo  output  32  product[31:0] or quotient.
REQ-011 ResultHi  output  32  product[63:32], remainder, or 0 for MUL.
REQ-012 MulFlags  output  4  {N,Z,C,V} of the result.

Function
REQ-013 The block SHALL implement FSM states IDLE, CALC, FIN and DONE.
REQ-014 IDLE: start=1 with a supported ALUControl SHALL capture the opcode and operands, clear the 6-bit counter, set busy=1 and move to CALC.
REQ-015 start with an unsupported ALUControl SHALL be ignored: stay in IDLE, busy=0, no done.
REQ-016 start SHALL be ignored in CALC, FIN and DONE; captured operands SHALL stay unchanged.
REQ-017 SMULL SHALL capture |SrcA| and |SrcB| as unsigned, plus sign = SrcA[31]^SrcB[31].
REQ-018 abs(0x80000000) SHALL be treated as unsigned 0x80000000.
REQ-019 CALC SHALL perform one radix-2 step per cycle for exactly 32 cycles, then move to FIN.
REQ-020 The multiply step SHALL be shift-add into a 64-bit accumulator.
REQ-021 The divide step SHALL be restoring unsigned division.
REQ-022 FIN SHALL load ResultHi/ResultLo and MulFlags, then move to DONE.
REQ-023 FIN SHALL apply a 64-bit two's-complement negate to the product when the SMULL sign is 1.
REQ-024 DONE SHALL drive done=1 and busy=0 for exactly one cycle, then return to IDLE.
REQ-025 Latency: with start sampled at edge E0, done SHALL be high between edges E34 and E35, for every operation.
REQ-026 A start present at edge E35 SHALL be accepted; back-to-back throughput is one operation per 35 cycles.
REQ-027 MUL SHALL give ResultLo=product[31:0] and ResultHi=0.
REQ-028 UMULL and SMULL SHALL give the full 64-bit product.
REQ-029 DIV SHALL give ResultLo=quotient and ResultHi=remainder.
REQ-030 DIV by 0 SHALL use the same latency and give ResultLo=0xFFFFFFFF and ResultHi=SrcA, the natural restoring outcome, with no exception.
REQ-031 For UMULL/SMULL, N SHALL equal ResultHi[31] and Z SHALL equal (64-bit result == 0).
REQ-032 For MUL/DIV, N SHALL equal ResultLo[31] and Z SHALL equal (ResultLo == 0).
REQ-033 C and V SHALL always be 0.
REQ-034 ResultLo, ResultHi and MulFlags SHALL hold their values from FIN until the next FIN.
REQ-035 Opcode or operand input changes after capture SHALL NOT affect an operation in flight.

Reset
REQ-036 On reset=1, independent of clk, the FSM SHALL go to IDLE.
REQ-037 On reset=1, busy, done, ResultLo, ResultHi, MulFlags, the counter and internal registers SHALL all go to 0.
REQ-038 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-039 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-040 UMULL, SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> done at E34; ResultHi=0xFFFFFFFE, ResultLo=0x00000001, N=1, Z=0.
REQ-041 SMULL, SrcA=0xFFFFFFFE (-2), SrcB=0x00000003 -> ResultHi=0xFFFFFFFF, ResultLo=0xFFFFFFFA, N=1.
REQ-042 SMULL, SrcA=SrcB=0x80000000 -> ResultHi=0x40000000, ResultLo=0, N=0, Z=0.
REQ-043 DIV, 100/7 -> ResultLo=14, ResultHi=2.
REQ-044 DIV, 5/0 -> ResultLo=0xFFFFFFFF, ResultHi=5, latency unchanged.
REQ-045 Protocol checks -> all four responses required:
- MUL 0x10000*0x10000 -> ResultLo=0, ResultHi=0, Z=1.
- start during busy -> ignored, one done only.
- ALUControl=0000 -> busy stays 0.
- reset at cycle 10 of an operation -> busy=0, outputs 0, no done.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: MUL, UMULL, SMULL (sign-magnitude) and unsigned DIV.
// Latency: start sampled at edge E0 -> done high between E34 and E35 for every op.
// Backpressure: none; start is ignored while busy, and a start during the done cycle is accepted.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic [3:0]       MulFlags
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_UMULL = 4'b0110;
  localparam logic [3:0] OP_SMULL = 4'b1000;
  localparam logic [3:0] OP_DIV   = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  // Captured operation. opnd is the multiplicand for multiplies and the
  // divisor for DIV; acc holds {high half, low half} of the working value.
  logic [3:0]         op;
  logic [WIDTH-1:0]   opnd;
  logic               sign;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic               supported;
  logic               accept;
  logic               busy_next;
  logic               done_next;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   opnd_init;
  logic [2*WIDTH-1:0] acc_init;
  logic               sign_init;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic [2*WIDTH-1:0] acc_step;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_lo;
  logic [WIDTH-1:0]   fin_hi;
  logic [3:0]         fin_flags;

  // Decode of the opcodes this unit accepts; anything else leaves it idle.
  always_comb begin
    supported = (ALUControl == OP_MUL)   || (ALUControl == OP_UMULL) ||
                (ALUControl == OP_SMULL) || (ALUControl == OP_DIV);
  end

  // Operand preparation at capture time. Unary minus of the most negative
  // value wraps back to itself, which is exactly its unsigned magnitude.
  always_comb begin
    abs_a     = SrcA[WIDTH-1] ? -SrcA : SrcA;
    abs_b     = SrcB[WIDTH-1] ? -SrcB : SrcB;
    opnd_init = SrcA;
    acc_init  = {{WIDTH{1'b0}}, SrcB};
    sign_init = 1'b0;
    case (ALUControl)
      OP_SMULL: begin
        opnd_init = abs_a;
        acc_init  = {{WIDTH{1'b0}}, abs_b};
        sign_init = SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
      end
      OP_DIV: begin
        opnd_init = SrcB;
        acc_init  = {{WIDTH{1'b0}}, SrcA};
      end
      default: begin
        opnd_init = SrcA;
        acc_init  = {{WIDTH{1'b0}}, SrcB};
      end
    endcase
  end

  // One radix-2 iteration: shift-add for multiplies, restoring step for DIV.
  always_comb begin
    // Multiply: the low half starts as the multiplier and is consumed LSB
    // first while the partial product grows into the high half.
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    // Divide: partial remainder shifted left with the next dividend bit.
    // The remainder is always below the divisor, so a set top bit of
    // shifted implies the subtraction succeeds and the result fits WIDTH.
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd});
    diff    = shifted[WIDTH-1:0] - opnd;
    if (op == OP_DIV) begin
      if (ge) begin
        acc_step = {diff, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc[0]) begin
        acc_step = {sum, acc[WIDTH-1:1]};
      end else begin
        acc_step = {1'b0, acc[2*WIDTH-1:1]};
      end
    end
  end

  // Result formatting and flags; the signed product is negated here only.
  always_comb begin
    prod      = sign ? -acc : acc;
    fin_lo    = acc[WIDTH-1:0];
    fin_hi    = acc[2*WIDTH-1:WIDTH];
    fin_flags = 4'b0000;
    case (op)
      OP_MUL: begin
        fin_lo    = acc[WIDTH-1:0];
        fin_hi    = '0;
        fin_flags = {acc[WIDTH-1], (acc[WIDTH-1:0] == '0), 2'b00};
      end
      OP_UMULL, OP_SMULL: begin
        fin_lo    = prod[WIDTH-1:0];
        fin_hi    = prod[2*WIDTH-1:WIDTH];
        fin_flags = {prod[2*WIDTH-1], (prod == '0), 2'b00};
      end
      default: begin
        // DIV: quotient in the low half, remainder in the high half.
        fin_lo    = acc[WIDTH-1:0];
        fin_hi    = acc[2*WIDTH-1:WIDTH];
        fin_flags = {acc[WIDTH-1], (acc[WIDTH-1:0] == '0), 2'b00};
      end
    endcase
  end

  // Next-state logic. busy/done are registered, so they follow the FSM by
  // one cycle: done is high while the FSM is already back in IDLE, which
  // lets a start in the done cycle be accepted.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy_next  = busy;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start && supported) begin
          accept     = 1'b1;
          busy_next  = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (cnt == LAST_STEP) begin
          state_next = FIN;
        end
      end
      FIN: begin
        state_next = DONE;
      end
      DONE: begin
        busy_next  = 1'b0;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers: capture, iterate, and publish results in FIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      op       <= 4'b0000;
      opnd     <= '0;
      sign     <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      ResultLo <= '0;
      ResultHi <= '0;
      MulFlags <= 4'b0000;
    end else begin
      busy <= busy_next;
      done <= done_next;
      if (accept) begin
        op   <= ALUControl;
        opnd <= opnd_init;
        acc  <= acc_init;
        sign <= sign_init;
        cnt  <= '0;
      end else if (state == CALC) begin
        acc <= acc_step;
        cnt <= cnt + CW'(1);
      end
      if (state == FIN) begin
        ResultLo <= fin_lo;
        ResultHi <= fin_hi;
        MulFlags <= fin_flags;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of expected results,
// checked with latency when done pulses, plus directed protocol scenarios.
module tb_muldiv_unit;

  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_UMULL = 4'b0110;
  localparam logic [3:0] OP_SMULL = 4'b1000;
  localparam logic [3:0] OP_DIV   = 4'b0111;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [3:0]  flags;
    int          e0;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        busy;
  logic        done;
  logic [31:0] ResultLo;
  logic [31:0] ResultHi;
  logic [3:0]  MulFlags;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done = 0;
  exp_t sb[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .ALUControl(ALUControl),
    .SrcA(SrcA),
    .SrcB(SrcB),
    .busy(busy),
    .done(done),
    .ResultLo(ResultLo),
    .ResultHi(ResultHi),
    .MulFlags(MulFlags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    logic        wide;
    p    = 64'd0;
    e.lo = 32'd0;
    e.hi = 32'd0;
    e.e0 = 0;
    wide = (op == OP_UMULL) || (op == OP_SMULL);
    case (op)
      OP_MUL: begin
        p = {32'd0, a} * {32'd0, b};
        e.lo = p[31:0];
        e.hi = 32'd0;
      end
      OP_UMULL: begin
        p = {32'd0, a} * {32'd0, b};
        e.lo = p[31:0];
        e.hi = p[63:32];
      end
      OP_SMULL: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        e.lo = p[31:0];
        e.hi = p[63:32];
      end
      default: begin
        if (b == 32'd0) begin
          e.lo = 32'hFFFF_FFFF;
          e.hi = a;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    if (wide) e.flags = {e.hi[31], ({e.hi, e.lo} == 64'd0), 2'b00};
    else      e.flags = {e.lo[31], (e.lo == 32'd0), 2'b00};
    return e;
  endfunction

  // Completion monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      n_done <= n_done + 1;
      if (sb.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("result_lo", {32'd0, ResultLo}, {32'd0, e.lo});
        chk("result_hi", {32'd0, ResultHi}, {32'd0, e.hi});
        chk("flags", {60'd0, MulFlags}, {60'd0, e.flags});
        chk("latency", 64'(cyc - e.e0), 64'd34);
        chk("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic acc_exp);
    exp_t e;
    @(posedge clk); #1;
    ALUControl = op;
    SrcA = a;
    SrcB = b;
    start = 1'b1;
    if (acc_exp) begin
      e = model(op, a, b);
      e.e0 = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    ALUControl = 4'($urandom);
    SrcA = $urandom;
    SrcB = $urandom;
    chk("accept_busy", {63'd0, busy}, {63'd0, acc_exp});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b, 1'b1);
    wait_drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops[4];
    int n0;
    int n;
    exp_t e;
    ops[0] = OP_MUL; ops[1] = OP_UMULL; ops[2] = OP_SMULL; ops[3] = OP_DIV;

    reset = 1'b1;
    start = 1'b0;
    ALUControl = 4'b0000;
    SrcA = 32'd0;
    SrcB = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_lo", {32'd0, ResultLo}, 64'd0);
    chk("rst_hi", {32'd0, ResultHi}, 64'd0);
    chk("rst_flags", {60'd0, MulFlags}, 64'd0);
    reset = 1'b0;

    // Directed vectors with hand-computed results.
    run(OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("umull_max_hi", {32'd0, ResultHi}, 64'h0000_0000_FFFF_FFFE);
    chk("umull_max_lo", {32'd0, ResultLo}, 64'h1);
    chk("umull_max_flags", {60'd0, MulFlags}, 64'b1000);

    run(OP_SMULL, 32'hFFFF_FFFE, 32'h0000_0003);
    chk("smull_neg_hi", {32'd0, ResultHi}, 64'h0000_0000_FFFF_FFFF);
    chk("smull_neg_lo", {32'd0, ResultLo}, 64'h0000_0000_FFFF_FFFA);
    chk("smull_neg_flags", {60'd0, MulFlags}, 64'b1000);

    run(OP_SMULL, 32'h8000_0000, 32'h8000_0000);
    chk("smull_min_hi", {32'd0, ResultHi}, 64'h0000_0000_4000_0000);
    chk("smull_min_lo", {32'd0, ResultLo}, 64'h0);
    chk("smull_min_flags", {60'd0, MulFlags}, 64'b0000);

    run(OP_DIV, 32'd100, 32'd7);
    chk("div_q", {32'd0, ResultLo}, 64'd14);
    chk("div_r", {32'd0, ResultHi}, 64'd2);

    run(OP_DIV, 32'd5, 32'd0);
    chk("div0_q", {32'd0, ResultLo}, 64'h0000_0000_FFFF_FFFF);
    chk("div0_r", {32'd0, ResultHi}, 64'd5);

    run(OP_MUL, 32'h0001_0000, 32'h0001_0000);
    chk("mul_wrap_lo", {32'd0, ResultLo}, 64'd0);
    chk("mul_wrap_hi", {32'd0, ResultHi}, 64'd0);
    chk("mul_wrap_flags", {60'd0, MulFlags}, 64'b0100);

    // Random operands across all opcodes.
    for (int i = 0; i < 24; i++) begin
      if (i % 8 == 3) run(ops[i % 4], $urandom, $urandom_range(1, 255));
      else            run(ops[i % 4], $urandom, $urandom);
    end

    // start while busy is ignored: one done, original operands' result.
    n0 = n_done;
    issue(OP_MUL, 32'd1234, 32'd5678, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    ALUControl = OP_UMULL;
    SrcA = 32'hFFFF_0000;
    SrcB = 32'h0000_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain();
    chk("busy_start_one_done", 64'(n_done - n0), 64'd1);
    chk("busy_start_result", {32'd0, ResultLo}, 64'd7006652);

    // Unsupported opcodes never start an operation.
    n0 = n_done;
    issue(4'b0000, 32'd7, 32'd9, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("unsup_busy", {63'd0, busy}, 64'd0);
    end
    issue(4'b1111, 32'd7, 32'd9, 1'b0);
    repeat (40) @(negedge clk);
    chk("unsup_no_done", 64'(n_done - n0), 64'd0);

    // Back-to-back: start during the done cycle is accepted at E35.
    issue(OP_UMULL, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    chk("b2b_done_seen", {63'd0, done}, 64'd1);
    start = 1'b1;
    ALUControl = OP_DIV;
    SrcA = 32'hDEAD_BEEF;
    SrcB = 32'd1000;
    e = model(OP_DIV, 32'hDEAD_BEEF, 32'd1000);
    e.e0 = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accept", {63'd0, busy}, 64'd1);
    wait_drain();

    // Reset ten cycles into an operation aborts it without a done pulse.
    issue(OP_DIV, 32'hCAFE_F00D, 32'h0000_1234, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_done", {63'd0, done}, 64'd0);
    chk("mid_rst_lo", {32'd0, ResultLo}, 64'd0);
    chk("mid_rst_hi", {32'd0, ResultHi}, 64'd0);
    chk("mid_rst_flags", {60'd0, MulFlags}, 64'd0);
    n0 = n_done;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (45) @(negedge clk);
    chk("mid_rst_no_done", 64'(n_done - n0), 64'd0);

    // First start after reset is accepted.
    run(OP_MUL, 32'd7, 32'd6);
    chk("post_rst_mul", {32'd0, ResultLo}, 64'd42);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
